// File: rtl/aes_pkg.sv
// Shared AES definitions: sizing constants, Rcon/GF(2^8) constants, key-schedule FSM
// encoding, and the single-source byte S-box used by the round blocks and key expansion.
package aes_pkg;

  localparam int NB_BYTE  = 8;
  localparam int N_BYTES  = 16;
  localparam int N_ROUNDS = 14;
  localparam int NB_WORD  = 32;
  localparam int NB_STATE = 128;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [NB_WORD-1:0] i_word,
  output logic [NB_WORD-1:0] o_word
);

  for (genvar b = 0; b < NB_WORD/NB_BYTE; b++) begin : g_byte
    assign o_word[b*NB_BYTE +: NB_BYTE] = sbox(i_word[b*NB_BYTE +: NB_BYTE]);
  end

endmodule

// File: rtl/aes_key_expansion_sequential.sv
// Iterative AES-256 key schedule: one 128-bit round key per enabled cycle into a 15-key vector.
// Build option AES_KEY_EXPANSION_ZEROIZE_EN clears stale slices on start and masks the vector until complete.
module aes_key_expansion_sequential #(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 14
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic [2*N_BYTES*NB_BYTE-1:0]             i_key,
  input  logic                                     i_start,
  input  logic                                     i_valid,
  output logic [N_BYTES*NB_BYTE*(N_ROUNDS+1)-1:0]  o_round_key_vector,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_key_valid
);
  import aes_pkg::*;

  localparam int KEY_W = 2*N_BYTES*NB_BYTE;
  localparam int RK_W  = N_BYTES*NB_BYTE;
  localparam int NKEYS = N_ROUNDS+1;

  if (NB_BYTE != 8 || N_BYTES != 16 || N_ROUNDS != 14) begin : g_bad_cfg
    $error("aes_key_expansion_sequential supports only AES-256 (8/16/14)");
  end

  state_e                    state_q, state_d;
  logic [3:0]                r_q, r_d;
  logic [7:0]                rcon_q, rcon_d;
  logic [7:0][NB_WORD-1:0]   w_q, w_d;
  logic [NKEYS-1:0][RK_W-1:0] rk_q, rk_d;
  logic                      done_q, done_d;
  logic                      kv_q, kv_d;

  logic                      even;
  logic [NB_WORD-1:0]        prev, sub_in, sub_out, temp;
  logic [3:0][NB_WORD-1:0]   nw;

  // w_q[7] is the most recent word w[4r-1], w_q[0] the oldest w[4r-8].
  assign even   = ~r_q[0];
  assign prev   = w_q[7];
  assign sub_in = even ? {prev[23:0], prev[31:24]} : prev;

  aes_subword u_subword (
    .i_word (sub_in),
    .o_word (sub_out)
  );

  assign temp  = sub_out ^ (even ? {rcon_q, 24'h0} : {NB_WORD{1'b0}});
  assign nw[0] = w_q[0] ^ temp;
  assign nw[1] = w_q[1] ^ nw[0];
  assign nw[2] = w_q[2] ^ nw[1];
  assign nw[3] = w_q[3] ^ nw[2];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
    rk_d    = rk_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    if (i_start) begin
      // Start has priority in every state, including over the final expand step.
      rk_d[0] = i_key[KEY_W-1 -: RK_W];
      rk_d[1] = i_key[RK_W-1:0];
`ifdef AES_KEY_EXPANSION_ZEROIZE_EN
      for (int k = 2; k < NKEYS; k++) rk_d[k] = '0;
`endif
      for (int k = 0; k < 8; k++) w_d[k] = i_key[KEY_W-1-NB_WORD*k -: NB_WORD];
      r_d     = 4'd2;
      rcon_d  = RCON_INIT;
      kv_d    = 1'b0;
      state_d = ST_EXPAND;
    end else if (state_q == ST_EXPAND && i_valid) begin
      rk_d[r_q] = {nw[0], nw[1], nw[2], nw[3]};
      w_d       = {nw, w_q[7:4]};
      if (even) rcon_d = xtime(rcon_q);
      if (r_q == 4'(N_ROUNDS)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        kv_d    = 1'b1;
      end else begin
        r_d = r_q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      rcon_q  <= '0;
      w_q     <= '0;
      rk_q    <= '0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rcon_q  <= rcon_d;
      w_q     <= w_d;
      rk_q    <= rk_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

`ifdef AES_KEY_EXPANSION_ZEROIZE_EN
  assign o_round_key_vector = kv_q ? rk_q : '0;
`else
  assign o_round_key_vector = rk_q;
`endif
  assign o_busy      = (state_q == ST_EXPAND);
  assign o_done      = done_q;
  assign o_key_valid = kv_q;

endmodule

// File: tb/tb_aes_key_expansion_sequential.sv
// Directed bench for the AES-256 key schedule using the FIPS-197 A.3 key and its expansion.
module tb_aes_key_expansion_sequential;

  localparam logic [255:0] A3_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [1919:0] A3_VEC = {
    128'hfe4890d1e6188d0b046df344706c631e,
    128'hcafaaae3e4d59b349adf6acebd10190d,
    128'h749c47ab18501ddae2757e4f7401905a,
    128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
    128'hde1369676ccc5a71fa2563959674ee15,
    128'hc814e20476a9fb8a5025c02d59c58239,
    128'h68007bacb2df331696e939e46c518d80,
    128'h98c5bfc9bebd198e268c3ba709e04214,
    128'h812c81addadf48ba24360af2fab8b464,
    128'hb5a9328a2678a647983122292f6c79b3,
    128'hd59aecb85bf3c917fee94248de8ebe96,
    128'ha8b09c1a93d194cdbe49846eb75d5b9a,
    128'h9ba354118e6925afa51a8b5f2067fcde,
    128'h1f352c073b6108d72d9810a30914dff4,
    128'h603deb1015ca71be2b73aef0857d7781};

  logic          clk, rst, start, valid;
  logic [255:0]  key;
  logic [1919:0] vec;
  logic          busy, done, kv;
  int            checks = 0;
  int            passed = 0;

  aes_key_expansion_sequential dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_key              (key),
    .i_start            (start),
    .i_valid            (valid),
    .o_round_key_vector (vec),
    .o_busy             (busy),
    .o_done             (done),
    .o_key_valid        (kv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bad_slice(input logic [1919:0] v, input logic [1919:0] e);
    for (int r = 0; r < 15; r++) if (v[r*128 +: 128] !== e[r*128 +: 128]) return r;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [255:0] k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs a fixed number of cycles, recording the first o_done cycle and pulse count.
  task automatic run(input int cyc, input bit tog, output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int n = 1; n <= cyc; n++) begin
      valid = tog ? (n % 2 == 0) : 1'b1;
      step();
      if (done) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    valid = 1'b1;
  endtask

  task automatic test_reset();
    int b;
    rst = 1'b0; start = 1'b0; valid = 1'b1; key = '0;
    #1 rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else passed++;
    checks++; if (kv !== 1'b0) $display("FAIL reset_key_valid got=%0b exp=0", kv); else passed++;
    b = bad_slice(vec, '0);
    checks++; if (b != -1) $display("FAIL reset_vector slice=%0d got=%h exp=0", b, vec[b*128 +: 128]); else passed++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int first, pulses, b;
    start_key(A3_KEY);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_after_start got=%0b exp=1", busy); else passed++;
    checks++; if (vec[255:0] !== A3_VEC[255:0] && vec[255:0] !== '0)
      $display("FAIL basic_rk01 got=%h exp=%h", vec[255:0], A3_VEC[255:0]); else passed++;
    run(30, 1'b0, first, pulses);
    checks++; if (first != 13) $display("FAIL basic_latency got=%0d exp=13", first); else passed++;
    checks++; if (pulses != 1) $display("FAIL basic_done_pulses got=%0d exp=1", pulses); else passed++;
    checks++; if (kv !== 1'b1) $display("FAIL basic_key_valid got=%0b exp=1", kv); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end got=%0b exp=0", busy); else passed++;
    checks++; if (vec[2*128 +: 128] !== 128'h9ba354118e6925afa51a8b5f2067fcde)
      $display("FAIL basic_rk2 got=%h exp=9ba354118e6925afa51a8b5f2067fcde", vec[2*128 +: 128]); else passed++;
    checks++; if (vec[14*128 +: 128] !== 128'hfe4890d1e6188d0b046df344706c631e)
      $display("FAIL basic_rk14 got=%h exp=fe4890d1e6188d0b046df344706c631e", vec[14*128 +: 128]); else passed++;
    b = bad_slice(vec, A3_VEC);
    checks++; if (b != -1) $display("FAIL basic_vector slice=%0d got=%h exp=%h", b, vec[b*128 +: 128], A3_VEC[b*128 +: 128]); else passed++;
  endtask

  task automatic test_stall();
    int first, pulses, b;
    start_key(A3_KEY);
    checks++; if (kv !== 1'b0) $display("FAIL stall_kv_cleared got=%0b exp=0", kv); else passed++;
    run(40, 1'b1, first, pulses);
    checks++; if (first != 26) $display("FAIL stall_latency got=%0d exp=26", first); else passed++;
    checks++; if (pulses != 1) $display("FAIL stall_done_pulses got=%0d exp=1", pulses); else passed++;
    b = bad_slice(vec, A3_VEC);
    checks++; if (b != -1) $display("FAIL stall_vector slice=%0d got=%h exp=%h", b, vec[b*128 +: 128], A3_VEC[b*128 +: 128]); else passed++;
  endtask

  task automatic test_hold_zeroize();
    int bad, first, pulses;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (vec !== A3_VEC || kv !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); else passed++;
    start_key('0);
    for (int n = 0; n < 3; n++) begin
`ifdef AES_KEY_EXPANSION_ZEROIZE_EN
      checks++; if (vec !== '0) $display("FAIL zeroize_mask cycle=%0d slice14=%h exp=0", n, vec[14*128 +: 128]); else passed++;
`else
      checks++; if (vec[14*128 +: 128] !== A3_VEC[14*128 +: 128] || vec[255:0] !== '0)
        $display("FAIL stale_slices cycle=%0d rk14=%h rk0=%h", n, vec[14*128 +: 128], vec[127:0]); else passed++;
`endif
      checks++; if (kv !== 1'b0) $display("FAIL restart_kv cycle=%0d got=%0b exp=0", n, kv); else passed++;
      step();
    end
    run(20, 1'b0, first, pulses);
  endtask

  task automatic test_restart();
    int first, pulses, early, b;
    early = 0;
    start_key('0);
    for (int n = 1; n <= 4; n++) begin
      step();
      if (done) early++;
    end
    start_key(A3_KEY);
    run(30, 1'b0, first, pulses);
    checks++; if (early + pulses != 1) $display("FAIL restart_done_count got=%0d exp=1", early + pulses); else passed++;
    checks++; if (first != 13) $display("FAIL restart_latency got=%0d exp=13", first); else passed++;
    b = bad_slice(vec, A3_VEC);
    checks++; if (b != -1) $display("FAIL restart_vector slice=%0d got=%h exp=%h", b, vec[b*128 +: 128], A3_VEC[b*128 +: 128]); else passed++;
  endtask

  task automatic test_start_final();
    int first, pulses, b;
    start_key('0);
    for (int n = 1; n <= 12; n++) step();
    start_key(A3_KEY);
    checks++; if (done !== 1'b0) $display("FAIL final_start_done got=%0b exp=0", done); else passed++;
    checks++; if (busy !== 1'b1 || kv !== 1'b0) $display("FAIL final_start_state busy=%0b kv=%0b exp busy=1 kv=0", busy, kv); else passed++;
    run(30, 1'b0, first, pulses);
    checks++; if (first != 13 || pulses != 1) $display("FAIL final_start_done first=%0d pulses=%0d exp 13/1", first, pulses); else passed++;
    b = bad_slice(vec, A3_VEC);
    checks++; if (b != -1) $display("FAIL final_start_vector slice=%0d got=%h exp=%h", b, vec[b*128 +: 128], A3_VEC[b*128 +: 128]); else passed++;
  endtask

  task automatic test_async_reset();
    int first, pulses, b;
    start_key(A3_KEY);
    for (int n = 1; n <= 6; n++) step();
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || kv !== 1'b0)
      $display("FAIL async_reset_flags busy=%0b done=%0b kv=%0b exp 0", busy, done, kv); else passed++;
    b = bad_slice(vec, '0);
    checks++; if (b != -1) $display("FAIL async_reset_vector slice=%0d got=%h exp=0", b, vec[b*128 +: 128]); else passed++;
    step();
    rst = 1'b0;
    step();
    start_key(A3_KEY);
    run(30, 1'b0, first, pulses);
    checks++; if (first != 13 || pulses != 1) $display("FAIL post_reset_done first=%0d pulses=%0d exp 13/1", first, pulses); else passed++;
    b = bad_slice(vec, A3_VEC);
    checks++; if (b != -1) $display("FAIL post_reset_vector slice=%0d got=%h exp=%h", b, vec[b*128 +: 128], A3_VEC[b*128 +: 128]); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hold_zeroize();
    test_restart();
    test_start_final();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion_sequential.md
Name: aes_key_expansion_sequential

Overview:
- Iterative AES-256 key schedule. Sits directly upstream of the sequential AES round ladder.
- Accepts one 256-bit cipher key. Produces one 128-bit round key per cycle into a packed vector of 15 round keys, which drives the ladder's i_round_key_vector.
- Signals completion so the ladder/GCTR control can trigger the first block.

Parameters:
- NB_BYTE, 8, bits per byte.
- N_BYTES, 16, bytes per state/round key.
- N_ROUNDS, 14, AES rounds. Only 14 (AES-256) is supported; any other combination of the three parameters is a bad configuration and is flagged at elaboration.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_key  in  2*N_BYTES*NB_BYTE (256)  cipher key, FIPS-197 byte 0 in [255:248].
- i_start  in  1  one-cycle load request; i_key is sampled on this edge.
- i_valid  in  1  clock-enable; expansion advances only when high.
- o_round_key_vector  out  N_BYTES*NB_BYTE*(N_ROUNDS+1) (1920)  round key r at [r*128 +: 128], FIPS byte 0 in the slice MSB.
- o_busy  out  1  expansion in progress.
- o_done  out  1  one-cycle pulse when the last round key is written.
- o_key_valid  out  1  level: vector complete and stable.

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; word buffer 0; counter 0.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE -> EXPAND on i_start.
  - EXPAND -> DONE when round key 14 is written.
  - DONE -> EXPAND on i_start; otherwise DONE holds.
- Start edge (any state):
  - Round key 0 = i_key[255:128]; round key 1 = i_key[127:0].
  - 8-word buffer w[i-8..i-1] loaded; counter r=2; Rcon index=1.
  - o_key_valid and o_done forced 0; o_busy=1 from the next cycle.
- EXPAND, per cycle with i_valid=1: compute round key r (words 4r..4r+3), write its slice, shift buffer by 4 words, r++.
  - r even: temp = SubWord(RotWord(w[4r-1])) ^ {Rcon,24'h0}; then Rcon doubles in GF(2^8) with poly 0x11B. Sequence is 01,02,04,08,10,20,40.
  - r odd: temp = SubWord(w[4r-1]), no Rcon.
  - w[4r] = w[4r-8] ^ temp; w[4r+k] = w[4r+k-8] ^ w[4r+k-1] for k=1..3, chained in the same cycle.
- i_valid=0 during EXPAND: full stall; no register changes.
- Latency: 13 enabled cycles after the start edge.
  - o_done is high in the cycle after round key 14 is written.
  - o_key_valid rises with o_done and holds until the next i_start or reset.
  - o_busy falls with o_done.
- Restart: i_start during EXPAND aborts and restarts with the new key; no o_done is emitted for the aborted key.
- Simultaneous i_start with the final expand step: start wins.
- Slices for round keys 2..14 hold stale values during EXPAND; consumers must qualify with o_key_valid.
- Reset mid-operation: immediate return to IDLE with all outputs cleared.

Optional Feature:
- Macro: AES_KEY_EXPANSION_ZEROIZE_EN.
- Defined:
  - i_start clears all slices 2..14 to zero on the start edge.
  - o_round_key_vector is masked to all-zero whenever o_key_valid=0.
  - Ensures no partial or stale key material reaches the ladder.
- Undefined: no masking; stale slices are visible as described above; saves 1920 AND gates.

Decomposition:
- Shared package aes_pkg:
  - NB_BYTE, N_BYTES, N_ROUNDS, NB_WORD=32, NB_STATE=128.
  - The Rcon initial value 8'h01 and the reduction polynomial 8'h1B.
  - The FSM state encoding.
- One sub-module aes_subword: 4 parallel S-box byte lookups on a 32-bit word, purely combinational. It reuses the byte S-box already used by the round blocks, so the LUT has a single source.

Test Plan:
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, i_valid=1 -> after 13 cycles o_done pulses once. Round key 2 = 9ba35411 8e6925af a51a8b5f 2067fcde. Round key 14 = fe4890d1 e6188d0b 046df344 706c631e.
- Same key with i_valid toggled 1/0 on alternate cycles -> o_done after 26 cycles; vector identical to the first test.
- Start with the all-zero key; at cycle 5 start again with the A.3 key -> exactly one o_done, 13 cycles after the second start; A.3 vector produced.
- Assert i_reset asynchronously at cycle 7 of an expansion -> o_busy, o_done, o_key_valid and the vector go 0 immediately, without waiting for a clock edge; the next start completes normally.
- After completion, i_start held low for 100 cycles -> vector and o_key_valid=1 are stable. With AES_KEY_EXPANSION_ZEROIZE_EN, a new start -> vector reads all-zero until the next o_done.
